// File: rtl/cmp_max_sequencer_if.sv
// Sample/strobe/display bus of the running-max sequencer.
// The sequencer (slave) consumes data/strb/disp and drives io_out.
// io_out layout: [7]=vld, [6]=lt, [5]=eq, [4]=gt, [3:0]=max or count.
interface cmp_max_sequencer_if;
    logic [3:0] data;
    logic       strb;
    logic       disp;
    logic [7:0] io_out;

    modport master (
        output data,
        output strb,
        output disp,
        input  io_out
    );

    modport slave (
        input  data,
        input  strb,
        input  disp,
        output io_out
    );
endinterface

// File: rtl/cmp_max_sequencer.sv
// Running-maximum tracker fed by an asynchronous strobe.
// Each accepted strobe captures a 4-bit sample, compares it with the
// running max, and latches gt/eq/lt flags plus a saturating sample count.
// io_out[3:0] shows the max (disp=0) or the count (disp=1).
module cmp_max_sequencer (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cmp_max_sequencer_if.slave   bus
);

    typedef enum logic {
        EMPTY,
        TRACK
    } state_e;

    state_e     state_q;
    state_e     state_d;

    // Strobe synchronizer, history flop and arming logic.
    logic       s1_q;
    logic       s2_q;
    logic       s3_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       armed_d;
    logic       sample_ev;

    // Datapath state.
    logic [3:0] max_q;
    logic [3:0] max_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       gt_q;
    logic       gt_d;
    logic       eq_q;
    logic       eq_d;
    logic       lt_q;
    logic       lt_d;
    logic       vld_q;
    logic       vld_d;

    // Synchronize the strobe, keep one cycle of history, and track arming.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= bus.strb;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
        end
    end

    // Arm on the first genuine low seen at s2; the zeros left in the
    // synchronizer by reset are not an observation of the pin, so arming
    // waits until two post-reset edges have refilled s1/s2 from the input.
    // This keeps a strobe held through reset release from counting.
    always_comb begin
        armed_d   = armed_q | (fill_q[1] & ~s2_q);
        sample_ev = s2_q & ~s3_q & armed_q;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the first event leaves EMPTY, only reset returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (sample_ev) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = EMPTY;
        endcase
    end

    // FSM outputs: datapath updates applied on an event, held otherwise.
    always_comb begin
        max_d = max_q;
        cnt_d = cnt_q;
        gt_d  = gt_q;
        eq_d  = eq_q;
        lt_d  = lt_q;
        vld_d = vld_q;
        if (sample_ev) begin
            vld_d = 1'b1;
            case (state_q)
                EMPTY: begin
                    max_d = bus.data;
                    cnt_d = 4'd1;
                    gt_d  = 1'b1;
                    eq_d  = 1'b0;
                    lt_d  = 1'b0;
                end
                default: begin
                    gt_d  = (bus.data > max_q);
                    eq_d  = (bus.data == max_q);
                    lt_d  = (bus.data < max_q);
                    if (bus.data > max_q) begin
                        max_d = bus.data;
                    end
                    if (cnt_q != 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    // Datapath registers; reset wins over a coincident event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= '0;
            cnt_q <= '0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            max_q <= max_d;
            cnt_q <= cnt_d;
            gt_q  <= gt_d;
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            vld_q <= vld_d;
        end
    end

    // Output packing with the display mux on the low nibble.
    always_comb begin
        bus.io_out = {vld_q, lt_q, eq_q, gt_q, (bus.disp ? cnt_q : max_q)};
    end

endmodule

// File: doc/cmp_max_sequencer.md
CMP_MAX_SEQUENCER -- requirements
Module: cmp_max_sequencer

Interface
REQ-001 Parameter: none; all widths are fixed (4-bit samples, 4-bit count).
REQ-002 io_in[0]  input  1  clk; all state updates on the rising edge.
REQ-003 io_in[1]  input  1  reset; synchronous and active-high.
REQ-004 io_in[5:2]  input  4  data; unsigned sample nibble, not synchronized.
REQ-005 io_in[6]  input  1  strb; asynchronous sample strobe (pin/button), active on rising edge.
REQ-006 io_in[7]  input  1  disp; 0 = show running max on io_out[3:0], 1 = show sample count.
REQ-007 io_out[3:0]  output  4  max or count, selected by disp (combinational mux).
REQ-008 io_out[4]  output  1  gt; the last sample exceeded the prior max, or was the first sample.
REQ-009 io_out[5]  output  1  eq; the last sample equalled the prior max.
REQ-010 io_out[6]  output  1  lt; the last sample was below the prior max.
REQ-011 io_out[7]  output  1  vld; at least one sample has been accepted since reset.

Function
REQ-012 strb SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3.
- A sample event is s2=1, s3=0, armed=1.
REQ-013 armed SHALL clear on reset and set on the first cycle in which s2=0.
- Consequence: a strobe held high through reset release produces no event until it is seen low.
REQ-014 On an event, data SHALL be captured on the same edge that updates all outputs.
- Outputs change on the 3rd rising clk edge after strb is first sampled high by s1.
- data SHALL be stable from the strb rising edge until 4 clk cycles after it; the bench enforces this.
REQ-015 FSM states and transitions:
- EMPTY (reset state) --event--> TRACK.
- TRACK --event--> TRACK.
- Only reset returns the FSM to EMPTY.
REQ-016 Event in EMPTY: max<=data, gt=1, eq=0, lt=0, vld=1, count<=1.
REQ-017 Event in TRACK: 4-bit unsigned compare of data vs max.
- Exactly one of gt, eq or lt SHALL be 1.
- max<=data only when gt=1; max is held on eq or lt.
REQ-018 gt, eq and lt SHALL hold their values until the next event; they are not pulses.
REQ-019 count SHALL increment by 1 per event and saturate at 15; no wrap to 0.
REQ-020 Successive events SHALL be separated by at least one s2-low cycle.
- A strb high pulse lasting any number of cycles yields exactly one event.
- Strobe glitches shorter than one clk period MAY be missed; they SHALL never produce more than one event.
REQ-021 disp SHALL affect only the io_out[3:0] mux, never internal state; toggling it mid-event is harmless.

Reset
REQ-022 While reset=1 at a rising edge, all state SHALL clear: s1=s2=s3=0, armed=0, FSM=EMPTY, max=0, count=0, gt=eq=lt=vld=0.
REQ-023 Reset SHALL take priority over a simultaneous event; that event is discarded.
REQ-024 Reset values seen at io_out: io_out=8'h00 for either value of disp.

Verification
REQ-025 Basic run: reset, then samples 5, 9, 9, 3 with disp=0.
- After each sample: {vld,lt,eq,gt,max} = 1,0,0,1,5 / 1,0,0,1,9 / 1,0,1,0,9 / 1,1,0,0,9.
- With disp=1, io_out[3:0]=4.
REQ-026 Latency: drive strb high just before edge k with data=7 after reset.
- io_out unchanged after edges k and k+1.
- After edge k+2: io_out[3:0]=7, io_out[7]=1, io_out[4]=1.
REQ-027 Saturation: 20 strobes of data=0.
- count reads 15, not 4; max=0.
- First sample gives gt=1; all later samples give eq=1.
REQ-028 Held strobe: strb=1 during and after reset deassertion for 10 cycles gives no event (vld=0).
- strb low for 3 cycles, then high, gives exactly one event.
- A strb pulse held high for 50 cycles counts once.
REQ-029 Reset mid-operation: after 3 samples, assert reset for 1 cycle on the same edge as an event.
- io_out=00 and FSM=EMPTY.
- The next sample of 2 gives max=2, gt=1, count=1.
